// File: rtl/reg_arb_pkg.sv
// Shared types and limits for the two-port register-file arbiter.
package reg_arb_pkg;

  typedef enum logic [2:0] {
    ARB   = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    RWAIT = 3'd3,
    RACK  = 3'd4
  } state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;
  // Wide enough to count the RWAIT cycles of the longest legal latency.
  localparam int CNT_W      = $clog2(RD_LAT_MAX);

endpackage

// File: rtl/reg_arbiter_if.sv
// Requester and register-file signals of reg_arbiter; slave = arbiter side,
// master = requesters plus register file.
interface reg_arbiter_if #(
  parameter int AW = 8
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [31:0]   wdata0;
  logic          ack0;
  logic [31:0]   rdata0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [31:0]   wdata1;
  logic          ack1;
  logic [31:0]   rdata1;

  logic          rm_rd;
  logic [AW-1:0] rm_raddr;
  logic          rm_wr;
  logic [AW-1:0] rm_waddr;
  logic [31:0]   rm_wdata;
  logic [31:0]   rm_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output ack0, rdata0, ack1, rdata1,
    output rm_rd, rm_raddr, rm_wr, rm_waddr, rm_wdata,
    input  rm_rdata
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  ack0, rdata0, ack1, rdata1,
    input  rm_rd, rm_raddr, rm_wr, rm_waddr, rm_wdata,
    output rm_rdata
  );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker; on a tie the port not granted last wins.
// Zero latency, no state: the caller owns and updates the last-granted pointer.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       any,
  output logic       sel
);

  assign any = |req;
  assign sel = (&req) ? ~last : req[1];

endmodule

// File: rtl/reg_arbiter.sv
// Two-requester register-file arbiter, one transaction in flight, all outputs registered.
// Write acks one cycle after the grant edge, read acks RD_LAT+1 cycles after; requesters hold req until ack.
module reg_arbiter
  import reg_arb_pkg::*;
#(
  parameter int AW     = 8,
  parameter int RD_LAT = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  reg_arbiter_if.slave   bus
);

  // Out-of-range latencies are clamped into the supported window.
  localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                       (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LAT >= 2) ? (LAT - 2) : 0);

  state_e           state_q;
  logic             last_q;
  logic             win_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ack0_q;
  logic             ack1_q;
  logic             rm_rd_q;
  logic             rm_wr_q;
  logic [AW-1:0]    rm_raddr_q;
  logic [AW-1:0]    rm_waddr_q;
  logic [31:0]      rm_wdata_q;
  logic [31:0]      cap_q;

  logic             any;
  logic             sel;
  logic             sel_we;
  logic [AW-1:0]    sel_addr;
  logic [31:0]      sel_wdata;

  rr_arb2 u_pick (
    .req  ({bus.req1, bus.req0}),
    .last (last_q),
    .any  (any),
    .sel  (sel)
  );

  assign sel_we    = sel ? bus.we1    : bus.we0;
  assign sel_addr  = sel ? bus.addr1  : bus.addr0;
  assign sel_wdata = sel ? bus.wdata1 : bus.wdata0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB;
      last_q     <= 1'b1;
      win_q      <= 1'b0;
      cnt_q      <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rm_rd_q    <= 1'b0;
      rm_wr_q    <= 1'b0;
      rm_raddr_q <= '0;
      rm_waddr_q <= '0;
      rm_wdata_q <= '0;
      cap_q      <= '0;
    end else begin
      // Strobes and acks are single-cycle pulses unless re-asserted below.
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rm_rd_q <= 1'b0;
      rm_wr_q <= 1'b0;
      case (state_q)
        ARB: begin
          if (any) begin
            win_q  <= sel;
            last_q <= sel;
            if (sel_we) begin
              state_q    <= WR;
              rm_wr_q    <= 1'b1;
              rm_waddr_q <= sel_addr;
              rm_wdata_q <= sel_wdata;
              ack0_q     <= ~sel;
              ack1_q     <= sel;
            end else begin
              state_q    <= RD;
              rm_rd_q    <= 1'b1;
              rm_raddr_q <= sel_addr;
            end
          end
        end
        WR: state_q <= ARB;
        RD: begin
          if (LAT == 1) begin
            state_q <= RACK;
            cap_q   <= bus.rm_rdata;
            ack0_q  <= ~win_q;
            ack1_q  <= win_q;
          end else begin
            state_q <= RWAIT;
            cnt_q   <= CNT_INIT;
          end
        end
        RWAIT: begin
          if (cnt_q == '0) begin
            state_q <= RACK;
            cap_q   <= bus.rm_rdata;
            ack0_q  <= ~win_q;
            ack1_q  <= win_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RACK:    state_q <= ARB;
        default: state_q <= ARB;
      endcase
    end
  end

  assign bus.ack0     = ack0_q;
  assign bus.ack1     = ack1_q;
  assign bus.rdata0   = cap_q;
  assign bus.rdata1   = cap_q;
  assign bus.rm_rd    = rm_rd_q;
  assign bus.rm_raddr = rm_raddr_q;
  assign bus.rm_wr    = rm_wr_q;
  assign bus.rm_waddr = rm_waddr_q;
  assign bus.rm_wdata = rm_wdata_q;

endmodule

// File: doc/reg_arbiter.md
REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 Parameter AW, default 8, register address width in words.
REQ-002 Parameter RD_LAT, default 2, legal range 1..4: register file read latency in cycles, counting the rm_rd cycle as cycle 1.
REQ-003 clk  in  1  single clock; all logic is posedge clk.
REQ-004 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-005 reqN  in  1  (N=0,1) requester N transaction request; held high until ackN.
REQ-006 weN  in  1  1=write, 0=read; stable while reqN high.
REQ-007 addrN  in  AW  register word address; stable while reqN high.
REQ-008 wdataN  in  32  write data; stable while reqN high.
REQ-009 ackN  out  1  one-cycle completion pulse to requester N.
REQ-010 rdataN  out  32  read data; valid only in the ackN cycle of a read.
REQ-011 rm_rd  out  1  register file read strobe.
REQ-012 rm_raddr  out  AW  register file read address.
REQ-013 rm_wr  out  1  register file write strobe.
REQ-014 rm_waddr  out  AW  register file write address.
REQ-015 rm_wdata  out  32  register file write data.
REQ-016 rm_rdata  in  32  register file read data.

Function
REQ-017 All outputs are registered; no combinational path from any input to any output.
REQ-018 States: ARB, WR, RD, RWAIT, RACK; exactly one transaction in flight.
REQ-019 ARB: if no reqN is high, stay in ARB; otherwise latch the winner's index, we, addr and wdata, and go to WR if we=1, else RD.
REQ-020 Arbitration: one request wins outright; if both are high, the port not granted last wins (round-robin); the last-granted pointer updates only on a grant.
REQ-021 WR (one cycle): rm_wr=1, rm_waddr/rm_wdata=latched values, ackN=1 for the winner; next state ARB.
REQ-022 RD (one cycle): rm_rd=1, rm_raddr=latched addr; next state RACK if RD_LAT=1, else RWAIT.
REQ-023 RWAIT: count RD_LAT-1 cycles; on the last one, go to RACK.
REQ-024 rm_rdata is captured into an internal 32-bit register at the clock edge ending cycle RD_LAT (RD is cycle 1).
REQ-025 RACK (one cycle): ackN=1 for the winner, rdata0 and rdata1 both driven from the capture register; next state ARB.
REQ-026 Latency, request first seen high at edge k in ARB:
  - write: ack during cycle k+1;
  - read: ack during cycle k+1+RD_LAT.
REQ-027 Back-to-back: the ARB cycle following an ack evaluates requests afresh; the acked requester has deasserted reqN by then.
REQ-028 Throughput with both ports saturated: one write per 2 cycles, one read per RD_LAT+2 cycles, grants alternating 0,1,0,1.
REQ-029 rm_raddr, rm_waddr, rm_wdata and the capture register hold their last value outside strobe cycles.
REQ-030 rm_rd and rm_wr are never high in the same cycle; ack0 and ack1 are never high in the same cycle.
REQ-031 A reqN that drops before its ackN is a protocol violation; the in-flight transaction still completes and its ack is still issued.

Reset
REQ-032 While rst_n=0: state=ARB, last-granted pointer=1 (port 0 wins the first tie), and every output and internal register is 0.
REQ-033 Reset asserted mid-transaction aborts it immediately with no ack. After release, arbitration restarts in ARB on the first clock edge.

Structure
REQ-034 Package reg_arb_pkg holds the state enum type and the RD_LAT legal-range bounds.
REQ-035 Sub-module rr_arb2 is a purely combinational two-way round-robin picker.
  - inputs: req[1:0], last;
  - outputs: any, sel.

Verification
REQ-036 Reset release, req0 write (addr=0x05, wdata=0xDEADBEEF) seen at edge k -> cycle k+1: rm_wr=1, rm_waddr=0x05, rm_wdata=0xDEADBEEF, ack0=1.
REQ-037 RD_LAT=2, req1 read addr=0x03 with the model returning 0x12345678 -> rm_rd=1 in cycle k+1, ack1=1 with rdata1=0x12345678 in cycle k+3.
REQ-038 req0 and req1 both held continuously for 4 writes -> grant order 0,1,0,1, an ack every 2nd cycle, never both acks in one cycle.
REQ-039 rst_n pulled low during RWAIT of a read -> all outputs 0 asynchronously and no ack; after release, a new req0 read completes with normal latency.
REQ-040 Sweep RD_LAT=1 and RD_LAT=4 -> read ack at k+2 and k+5 respectively, with data matching the model.
